// File: rtl/mcb_dat_pipe_ctrl.sv
// rtl/mcb_dat_pipe_ctrl.sv - data-phase controller for SDR SDRAM column commands
//
// Turns read/write column commands into DQ input/output enables, write-load
// strobes and user-side read-valid / write-request handshakes.
//
// Ports:
//   mcb_clk, mcb_rst, mcb_sclr   clock, sync active-high reset and soft clear
//   cfg_cl                       CAS latency (0 behaves as 1)
//   c_rd/c_rda/c_wr/c_wra        column commands from the sequencer
//   c_bst_num                    burst units minus one for the command
//   c_wdat_req                   write pre-request, one cycle ahead of c_wr
//   d_dp_ie/d_dp_oe/d_wr_ld      DQ datapath controls
//   mcb_wdat_req/mcb_wdat_last   user write-data request and its final beat
//   mcb_rdat_vld/mcb_rdat_last   user read-data valid and its final beat
//   d_busy, d_err                activity flag, write-over-read error pulse
module mcb_dat_pipe_ctrl #(
    parameter int CL_MAX    = 3,
    parameter int BST_W     = 2,
    parameter int BEAT_UNIT = 4,
    localparam int CLW      = $clog2(CL_MAX + 1),
    localparam int NMAX     = (2 ** BST_W) * BEAT_UNIT,
    localparam int BCW      = $clog2(NMAX)
) (
    input  logic             mcb_clk,
    input  logic             mcb_rst,
    input  logic             mcb_sclr,
    input  logic [CLW-1:0]   cfg_cl,
    input  logic             c_rd,
    input  logic             c_rda,
    input  logic             c_wr,
    input  logic             c_wra,
    input  logic [BST_W-1:0] c_bst_num,
    input  logic             c_wdat_req,
    output logic             d_dp_ie,
    output logic             d_dp_oe,
    output logic             d_wr_ld,
    output logic             mcb_wdat_req,
    output logic             mcb_wdat_last,
    output logic             mcb_rdat_vld,
    output logic             mcb_rdat_last,
    output logic             d_busy,
    output logic             d_err
);

    // Registered CAS stages; the live command acts as tap 0, so CL_MAX-1
    // registers are enough to reach a launch at cfg_cl-1 cycles of delay.
    localparam int DLN = (CL_MAX > 1) ? CL_MAX - 1 : 1;

    // One bit wider than the beat counters so a length of NMAX fits.
    typedef logic [BCW:0] len_t;

    function automatic len_t burst_len(input logic [BST_W-1:0] b);
        return len_t'((int'(b) + 1) * BEAT_UNIT);
    endfunction

    logic             clr;
    logic             rd_cmd;
    logic             wr_cmd;
    logic [CLW-1:0]   cl_eff;
    len_t             cmd_n;

    logic [BCW-1:0]   wb;
    len_t             wn;
    len_t             wb_x;

    logic [DLN-1:0]   dl_v;
    logic [BST_W-1:0] dl_b [DLN];
    logic             launch_v;
    logic [BST_W-1:0] launch_b;
    logic             dl_pend;
    logic             rd_pend;

    logic [BCW-1:0]   rb;
    len_t             rn;
    len_t             rb_x;

    always_comb begin
        clr    = mcb_rst | mcb_sclr;
        rd_cmd = (c_rd | c_rda) & ~clr;
        wr_cmd = (c_wr | c_wra) & ~clr;
        cmd_n  = burst_len(c_bst_num);
        if (cfg_cl == '0)
            cl_eff = CLW'(1);
        else if (int'(cfg_cl) > CL_MAX)
            cl_eff = CLW'(CL_MAX);
        else
            cl_eff = cfg_cl;
        wb_x = {1'b0, wb};
        rb_x = {1'b0, rb};
    end

    // Write-side strobes are combinational so the user sees the request a
    // full cycle before the output register loads.
    always_comb begin
        d_wr_ld       = wr_cmd | (d_dp_oe & (wb_x + len_t'(1) < wn));
        mcb_wdat_req  = (c_wdat_req & ~clr)
                      | (wr_cmd & (cmd_n >= len_t'(2)))
                      | (d_dp_oe & (wb_x + len_t'(2) < wn));
        mcb_wdat_last = (wr_cmd & (cmd_n == len_t'(2)))
                      | (d_dp_oe & (wb_x + len_t'(3) == wn));
    end

    // Launch tap: a read launches the cycle before its first d_dp_ie beat.
    // Stages beyond the tap have already launched and no longer count as
    // pending.
    always_comb begin
        launch_v = 1'b0;
        launch_b = '0;
        dl_pend  = 1'b0;
        if (cl_eff == CLW'(1)) begin
            launch_v = rd_cmd;
            launch_b = c_bst_num;
        end
        for (int i = 0; i < DLN; i++) begin
            if (int'(cl_eff) == i + 2) begin
                launch_v = dl_v[i];
                launch_b = dl_b[i];
            end
            if (i + 2 <= int'(cl_eff))
                dl_pend = dl_pend | dl_v[i];
        end
        rd_pend = dl_pend | d_dp_ie;
        d_busy  = d_dp_oe | d_dp_ie | dl_pend | mcb_rdat_vld;
    end

    always_ff @(posedge mcb_clk) begin
        if (clr) begin
            d_dp_oe       <= 1'b0;
            wb            <= '0;
            wn            <= '0;
            dl_v          <= '0;
            for (int i = 0; i < DLN; i++)
                dl_b[i] <= '0;
            d_dp_ie       <= 1'b0;
            rb            <= '0;
            rn            <= '0;
            mcb_rdat_vld  <= 1'b0;
            mcb_rdat_last <= 1'b0;
            d_err         <= 1'b0;
        end else begin
            // Write burst: a new write restarts, a read truncates.
            if (wr_cmd) begin
                d_dp_oe <= 1'b1;
                wb      <= '0;
                wn      <= cmd_n;
            end else if (rd_cmd) begin
                d_dp_oe <= 1'b0;
            end else if (d_dp_oe) begin
                wb <= wb + BCW'(1);
                if (wb_x + len_t'(1) == wn)
                    d_dp_oe <= 1'b0;
            end

            // CAS delay line; a write flushes every queued read.
            dl_v[0] <= rd_cmd;
            dl_b[0] <= c_bst_num;
            for (int i = 1; i < DLN; i++) begin
                dl_v[i] <= dl_v[i-1] & ~wr_cmd;
                dl_b[i] <= dl_b[i-1];
            end

            // Read burst: a later launch replaces the running one.
            if (wr_cmd) begin
                d_dp_ie <= 1'b0;
            end else if (launch_v) begin
                d_dp_ie <= 1'b1;
                rb      <= '0;
                rn      <= burst_len(launch_b);
            end else if (d_dp_ie) begin
                rb <= rb + BCW'(1);
                if (rb_x + len_t'(1) == rn)
                    d_dp_ie <= 1'b0;
            end

            mcb_rdat_vld  <= d_dp_ie;
            mcb_rdat_last <= d_dp_ie & (rb_x + len_t'(1) == rn);
            d_err         <= wr_cmd & rd_pend;
        end
    end

endmodule

// File: tb/tb_mcb_dat_pipe_ctrl.sv
// tb/tb_mcb_dat_pipe_ctrl.sv - self-checking bench for mcb_dat_pipe_ctrl
module tb_mcb_dat_pipe_ctrl;

    localparam int CL_MAX    = 3;
    localparam int BST_W     = 2;
    localparam int BEAT_UNIT = 4;
    localparam int CLW       = 2;
    localparam int MAXC      = 4096;

    localparam int C_NONE = 0;
    localparam int C_RD   = 1;
    localparam int C_RDA  = 2;
    localparam int C_WR   = 3;
    localparam int C_WRA  = 4;

    logic             mcb_clk = 1'b0;
    logic             mcb_rst = 1'b0;
    logic             mcb_sclr = 1'b0;
    logic [CLW-1:0]   cfg_cl = CLW'(2);
    logic             c_rd = 1'b0;
    logic             c_rda = 1'b0;
    logic             c_wr = 1'b0;
    logic             c_wra = 1'b0;
    logic [BST_W-1:0] c_bst_num = '0;
    logic             c_wdat_req = 1'b0;
    logic             d_dp_ie;
    logic             d_dp_oe;
    logic             d_wr_ld;
    logic             mcb_wdat_req;
    logic             mcb_wdat_last;
    logic             mcb_rdat_vld;
    logic             mcb_rdat_last;
    logic             d_busy;
    logic             d_err;

    always #5 mcb_clk = ~mcb_clk;

    mcb_dat_pipe_ctrl #(
        .CL_MAX    (CL_MAX),
        .BST_W     (BST_W),
        .BEAT_UNIT (BEAT_UNIT)
    ) dut (
        .mcb_clk       (mcb_clk),
        .mcb_rst       (mcb_rst),
        .mcb_sclr      (mcb_sclr),
        .cfg_cl        (cfg_cl),
        .c_rd          (c_rd),
        .c_rda         (c_rda),
        .c_wr          (c_wr),
        .c_wra         (c_wra),
        .c_bst_num     (c_bst_num),
        .c_wdat_req    (c_wdat_req),
        .d_dp_ie       (d_dp_ie),
        .d_dp_oe       (d_dp_oe),
        .d_wr_ld       (d_wr_ld),
        .mcb_wdat_req  (mcb_wdat_req),
        .mcb_wdat_last (mcb_wdat_last),
        .mcb_rdat_vld  (mcb_rdat_vld),
        .mcb_rdat_last (mcb_rdat_last),
        .d_busy        (d_busy),
        .d_err         (d_err)
    );

    // Command history; the reference model answers every question by
    // looking back over it.
    bit h_rd   [MAXC];
    bit h_wr   [MAXC];
    bit h_wreq [MAXC];
    bit h_clr  [MAXC];
    int h_bst  [MAXC];
    int h_cl   [MAXC];

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;

    function automatic int blen(int t);
        return (h_bst[t] + 1) * BEAT_UNIT;
    endfunction

    // Last clear strictly before c; commands at or before it never happened.
    function automatic int floor_of(int c);
        for (int t = c - 1; t >= 0; t--)
            if (h_clr[t]) return t;
        return -1;
    endfunction

    // Reads issued at or before the last write are discarded.
    function automatic int read_base(int c);
        int lo;
        lo = floor_of(c);
        for (int t = c - 1; t > lo; t--)
            if (h_wr[t]) return t;
        return lo;
    endfunction

    function automatic int latest_col(int c);
        int lo;
        lo = floor_of(c);
        for (int t = c - 1; t > lo; t--)
            if (h_rd[t] || h_wr[t]) return t;
        return -1;
    endfunction

    function automatic bit oe_m(int c);
        int t;
        t = latest_col(c);
        return (t >= 0) && h_wr[t] && (c - t <= blen(t));
    endfunction

    function automatic bit wrld_m(int c);
        int t;
        t = latest_col(c);
        return h_wr[c] || ((t >= 0) && h_wr[t] && (c - t < blen(t)));
    endfunction

    function automatic bit req_m(int c);
        int t;
        t = latest_col(c);
        return h_wreq[c] || (h_wr[c] && blen(c) >= 2)
            || ((t >= 0) && h_wr[t] && (c - t <= blen(t) - 2));
    endfunction

    function automatic bit wlast_m(int c);
        int t;
        t = latest_col(c);
        return (h_wr[c] && blen(c) == 2)
            || ((t >= 0) && h_wr[t] && (c - t == blen(t) - 2));
    endfunction

    // The newest read whose data window has opened owns the DQ input;
    // returns its beat index or -1 once its window has closed.
    function automatic void read_state(input int x, output int beat, output int len);
        int base;
        base = read_base(x);
        beat = -1;
        len  = 0;
        for (int t = x - 1; t > base; t--) begin
            if (h_rd[t] && (t + h_cl[t] <= x)) begin
                len = blen(t);
                if (x - t - h_cl[t] < len) beat = x - t - h_cl[t];
                return;
            end
        end
    endfunction

    function automatic bit dl_pend_m(int x);
        int base;
        base = read_base(x);
        for (int t = x - 1; t > base; t--)
            if (h_rd[t] && (t + h_cl[t] - 1 >= x)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_cycle(input int c);
        int  beat, len, pbeat, plen;
        bit  ie_e, vld_e, last_e, err_e, busy_e;
        read_state(c, beat, len);
        ie_e = (beat >= 0);
        vld_e = 1'b0;
        last_e = 1'b0;
        err_e = 1'b0;
        if (c > 0 && !h_clr[c-1]) begin
            read_state(c - 1, pbeat, plen);
            vld_e  = (pbeat >= 0);
            last_e = (pbeat >= 0) && (pbeat == plen - 1);
            err_e  = h_wr[c-1] && ((pbeat >= 0) || dl_pend_m(c - 1));
        end
        busy_e = oe_m(c) || ie_e || vld_e || dl_pend_m(c);
        check_bit("d_dp_oe", d_dp_oe, oe_m(c));
        check_bit("d_dp_ie", d_dp_ie, ie_e);
        check_bit("mcb_rdat_vld", mcb_rdat_vld, vld_e);
        check_bit("mcb_rdat_last", mcb_rdat_last, last_e);
        check_bit("d_err", d_err, err_e);
        check_bit("d_busy", d_busy, busy_e);
        if (!h_clr[c]) begin
            check_bit("d_wr_ld", d_wr_ld, wrld_m(c));
            check_bit("mcb_wdat_req", mcb_wdat_req, req_m(c));
            check_bit("mcb_wdat_last", mcb_wdat_last, wlast_m(c));
        end
    endtask

    // clr: 0 none, 1 mcb_rst, 2 mcb_sclr
    task automatic step(input int cmd, input int bst, input bit wreq, input int clr);
        @(posedge mcb_clk);
        #1;
        c_rd       = (cmd == C_RD);
        c_rda      = (cmd == C_RDA);
        c_wr       = (cmd == C_WR);
        c_wra      = (cmd == C_WRA);
        c_bst_num  = BST_W'(bst);
        c_wdat_req = wreq;
        mcb_rst    = (clr == 1);
        mcb_sclr   = (clr == 2);
        h_rd[cyc]   = (cmd == C_RD) || (cmd == C_RDA);
        h_wr[cyc]   = (cmd == C_WR) || (cmd == C_WRA);
        h_wreq[cyc] = wreq;
        h_clr[cyc]  = (clr != 0);
        h_bst[cyc]  = bst;
        h_cl[cyc]   = (cfg_cl == '0) ? 1 : int'(cfg_cl);
        @(negedge mcb_clk);
        if (cyc > 0) check_cycle(cyc);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(C_NONE, 0, 1'b0, 0);
    endtask

    task automatic random_block(input int cl, input int n);
        int r;
        cfg_cl = CLW'(cl);
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 99);
            step((r < 55) ? C_NONE : (r < 70) ? C_RD : (r < 76) ? C_RDA :
                 (r < 91) ? C_WR : (r < 97) ? C_WRA : C_NONE,
                 $urandom_range(0, 3), ($urandom_range(0, 4) == 0),
                 (r == 99) ? 2 : (r == 98) ? 1 : 0);
        end
        idle(30);
    endtask

    initial begin
        step(C_NONE, 0, 1'b0, 1);
        step(C_NONE, 0, 1'b0, 1);
        idle(3);

        // Single read, CL 2.
        cfg_cl = CLW'(2);
        step(C_RD, 0, 1'b0, 0);
        idle(10);

        // Pre-requested write of two units.
        step(C_NONE, 0, 1'b1, 0);
        step(C_WR, 1, 1'b0, 0);
        idle(12);

        // Gapless reads, CL 3.
        cfg_cl = CLW'(3);
        step(C_RD, 0, 1'b0, 0);
        idle(3);
        step(C_RD, 0, 1'b0, 0);
        idle(12);

        // Long write truncated by a read.
        step(C_WR, 3, 1'b0, 0);
        idle(3);
        step(C_RD, 0, 1'b0, 0);
        idle(25);

        // Write over a pending read.
        step(C_RD, 0, 1'b0, 0);
        step(C_WR, 0, 1'b0, 0);
        idle(10);

        // Reset kills an in-flight read.
        step(C_RD, 0, 1'b0, 0);
        idle(1);
        step(C_NONE, 0, 1'b0, 1);
        idle(10);

        // Gapless writes, write restart, soft clear mid-burst.
        step(C_WR, 0, 1'b0, 0);
        idle(3);
        step(C_WRA, 0, 1'b0, 0);
        idle(8);
        step(C_WR, 2, 1'b0, 0);
        idle(2);
        step(C_WRA, 0, 1'b0, 0);
        idle(10);
        step(C_WR, 3, 1'b0, 0);
        idle(2);
        step(C_RDA, 1, 1'b0, 2);
        idle(10);

        random_block(1, 300);
        random_block(2, 300);
        random_block(3, 300);
        random_block(0, 300);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/mcb_dat_pipe_ctrl.md
# mcb_dat_pipe_ctrl

Parametrised data-phase controller for the sdrc_lite SDR SDRAM back-end, sitting between the command sequencer and the DQ datapath registers. For every read or write column command it generates the DQ input/output enables, write-load strobes and the user-side read-valid and write-request handshakes. It supports a runtime CAS latency, a parametrised burst-length unit, back-to-back gapless bursts and SDR burst interruption (read/write truncation by a later column command).

## Interface
- CL_MAX, 3: largest supported CAS latency; CLW = clog2(CL_MAX+1).
- BST_W, 2: width of c_bst_num.
- BEAT_UNIT, 4: beats per burst unit; burst length N = (c_bst_num+1)*BEAT_UNIT; NMAX = 2^BST_W*BEAT_UNIT; BCW = clog2(NMAX).

- mcb_clk  in  1  single clock, all logic on rising edge.
- mcb_rst  in  1  reset, synchronous, active-high.
- mcb_sclr  in  1  synchronous soft clear, active-high, same effect as mcb_rst.
- cfg_cl  in  CLW  CAS latency, 1..CL_MAX; 0 treated as 1; changed only when d_busy=0.
- c_rd, c_rda  in  1  read / read-autoprecharge issued this cycle.
- c_wr, c_wra  in  1  write / write-autoprecharge issued this cycle.
- c_bst_num  in  BST_W  burst units minus one, valid with any column command.
- c_wdat_req  in  1  pre-request from sequencer, one cycle before a write command.
- d_dp_ie  out  1  DQ input register enable.
- d_dp_oe  out  1  DQ output enable.
- d_wr_ld  out  1  write-data output register load.
- mcb_wdat_req  out  1  user write-data request (data due next cycle).
- mcb_wdat_last  out  1  mcb_wdat_req for the final beat.
- mcb_rdat_vld  out  1  user read-data valid.
- mcb_rdat_last  out  1  final beat of a read burst, qualifies mcb_rdat_vld.
- d_busy  out  1  any burst active or read in CAS pipeline.
- d_err  out  1  one-cycle pulse: write command while read data pending/active.

## Operation
- Command inputs one-hot per cycle; RD = c_rd|c_rda, WR = c_wr|c_wra.
- Write path: beat counter wb (BCW bits), write-length register wn. WR at T: wb<=0, wn<=N, d_dp_oe=1 for T+1..T+N (wb=k at T+1+k).
- d_wr_ld combinational = WR | (d_dp_oe & wb<wn-1).
- mcb_wdat_req combinational = c_wdat_req | (WR & N>=2) | (d_dp_oe & wb<wn-2); mcb_wdat_last marks the request of beat N-1.
- Read path: CAS delay line CL_MAX stages carrying {valid, bst_num}; RD enters at T, emerges at tap cfg_cl, starting read burst: d_dp_ie=1 for T+CL .. T+CL+N-1, counter rb.
- mcb_rdat_vld = d_dp_ie delayed one register; mcb_rdat_last = registered (d_dp_ie & rb==rn-1).
- Gapless: command at T+N (write) or launch emerging in the last beat cycle (read) continues with no idle cycle.
- Interrupt write: new WR during write burst restarts wb/wn; RD during write burst forces d_dp_oe=0 from T+1 (truncation).
- Interrupt read: a new read launch emerging mid-burst replaces rb/rn; old beats dropped.
- WR while delay line or read burst non-empty: d_err pulse T+1, delay line and read burst flushed, write proceeds normally.
- d_busy = d_dp_oe | d_dp_ie | any delay-line valid | mcb_rdat_vld.
- Counter arithmetic BCW bits, no wrap reachable (reset at every start).

## Timing
- Reset/sclr: all registers and outputs 0 next edge; in-flight bursts and delay line discarded; commands in the same cycle ignored.
- Write: cmd->first dp_oe 1 cycle; req leads wr_ld by 1 cycle; wr_ld leads dp_oe by 1.
- Read: cmd->first dp_ie cfg_cl cycles; dp_ie->rdat_vld 1 cycle.
- Combinational outputs: d_wr_ld, mcb_wdat_req, mcb_wdat_last; all others registered.

## Test plan
- cfg_cl=2, c_rd bst=0 at T=10 -> d_dp_ie 12..15, mcb_rdat_vld 13..16, mcb_rdat_last at 16, d_busy 0 at 17.
- c_wdat_req at 9, c_wr bst=1 at 10 -> mcb_wdat_req 9..16, d_wr_ld 10..17, d_dp_oe 11..18, wdat_last at 16.
- cfg_cl=3, c_rd bst=0 at 10 and 14 -> d_dp_ie continuous 13..20, two rdat_last pulses (17, 21).
- c_wr bst=3 at 10, c_rd at 14 -> d_dp_oe 11..14 only; d_dp_ie starts 14+cfg_cl.
- c_rd at 10 (cl=3), c_wr at 11 -> d_err at 12, no d_dp_ie, d_dp_oe 12..15.
- c_rd at 10, mcb_rst at 12 -> all outputs 0 from 13, no dp_ie.
